ex_stage_seq: RTL

//  Execute-stage sequencer directly upstream of the 32-bit ALU.
//  - Accepts decoded ops from ID over a valid/ready handshake.
//  - Registers operands and drives the ALU's 3-bit operation code.
//  - Captures the ALU result, zero flag and derived overflow into an output register toward MEM/WB.
//  - Holds results under downstream back-pressure; supports pipeline flush.

---
 rtl/ex_stage_seq_if.sv | 60 ++++++
 rtl/ex_stage_seq.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_seq_if.sv
// Bundle of ID-side, ALU-side and MEM/WB-side signals of the execute-stage sequencer.
// The ovf_trap signal exists only when OVF_TRAP_EN is defined.
interface ex_stage_seq_if #(
  parameter int unsigned W    = 32,
  parameter int unsigned RD_W = 5
);

  // ID side
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      in_class;
  logic [5:0]      in_funct;
  logic [W-1:0]    in_a;
  logic [W-1:0]    in_b;
  logic [RD_W-1:0] in_rd;

  // ALU side
  logic [2:0]      alu_operation;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [W-1:0]    alu_res;
  logic            alu_zero;

  // MEM/WB side
  logic            out_valid;
  logic            out_ready;
  logic [W-1:0]    out_res;
  logic            out_zero;
  logic [RD_W-1:0] out_rd;
  logic            out_wen;
  logic            out_ovf;
  logic            busy;
`ifdef OVF_TRAP_EN
  logic            ovf_trap;
`endif

  // Sequencer view
  modport slave (
    input  flush, in_valid, in_class, in_funct, in_a, in_b, in_rd,
    input  alu_res, alu_zero, out_ready,
`ifdef OVF_TRAP_EN
    output ovf_trap,
`endif
    output in_ready, alu_operation, alu_a, alu_b,
    output out_valid, out_res, out_zero, out_rd, out_wen, out_ovf, busy
  );

  // Environment view (ID, ALU and MEM/WB together)
  modport master (
    output flush, in_valid, in_class, in_funct, in_a, in_b, in_rd,
    output alu_res, alu_zero, out_ready,
`ifdef OVF_TRAP_EN
    input  ovf_trap,
`endif
    input  in_ready, alu_operation, alu_a, alu_b,
    input  out_valid, out_res, out_zero, out_rd, out_wen, out_ovf, busy
  );

endinterface

// File: rtl/ex_stage_seq.sv
// Execute-stage sequencer in front of the 32-bit ALU: accepts a decoded op,
// registers operands and ALU opcode, captures the ALU result with zero flag,
// signed overflow and write enable, and holds it until MEM/WB takes it.
// Optional feature macro: OVF_TRAP_EN (overflowing add/sub suppresses the
// register write and sets a sticky ovf_trap output).
module ex_stage_seq #(
  parameter int unsigned W    = 32,
  parameter int unsigned RD_W = 5
) (
  input logic           clk,
  input logic           rst,
  ex_stage_seq_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_DONE = 2'b10;

  localparam logic [1:0] CLS_ADD = 2'b00;
  localparam logic [1:0] CLS_SUB = 2'b01;
  localparam logic [1:0] CLS_R   = 2'b10;
  localparam logic [1:0] CLS_LUI = 2'b11;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_NULL = 3'b100;
  localparam logic [2:0] OP_SRL  = 3'b101;
  localparam logic [2:0] OP_LUI  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SLT = 6'b101010;

  logic [1:0]      state_q,     state_d;
  logic [2:0]      alu_op_q,    alu_op_d;
  logic [W-1:0]    alu_a_q,     alu_a_d;
  logic [W-1:0]    alu_b_q,     alu_b_d;
  logic [RD_W-1:0] rd_pend_q,   rd_pend_d;
  logic            wen_pend_q,  wen_pend_d;
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_res_q,   out_res_d;
  logic            out_zero_q,  out_zero_d;
  logic [RD_W-1:0] out_rd_q,    out_rd_d;
  logic            out_wen_q,   out_wen_d;
  logic            out_ovf_q,   out_ovf_d;
  logic            busy_q,      busy_d;
`ifdef OVF_TRAP_EN
  logic            ovf_trap_q,  ovf_trap_d;
`endif

  logic [2:0] dec_op_c;
  logic       dec_legal_c;
  logic       dec_wen_c;
  logic       in_ready_c;
  logic       accept_c;
  logic       ovf_c;

  // Decode class/funct into the ALU opcode; unknown R-type funct maps to null
  always_comb begin
    dec_op_c    = OP_NULL;
    dec_legal_c = 1'b1;
    case (bus.in_class)
      CLS_ADD: dec_op_c = OP_ADD;
      CLS_SUB: dec_op_c = OP_SUB;
      CLS_LUI: dec_op_c = OP_LUI;
      CLS_R: begin
        case (bus.in_funct)
          FN_ADD:  dec_op_c = OP_ADD;
          FN_SUB:  dec_op_c = OP_SUB;
          FN_AND:  dec_op_c = OP_AND;
          FN_OR:   dec_op_c = OP_OR;
          FN_SRL:  dec_op_c = OP_SRL;
          FN_SLT:  dec_op_c = OP_SLT;
          default: begin
            dec_op_c    = OP_NULL;
            dec_legal_c = 1'b0;
          end
        endcase
      end
      default: begin
        dec_op_c    = OP_NULL;
        dec_legal_c = 1'b0;
      end
    endcase
    dec_wen_c = dec_legal_c & (bus.in_class != CLS_SUB);
  end

  // Ready in IDLE, or in DONE when the held result leaves this cycle; never during flush
  always_comb begin
    in_ready_c = 1'b0;
    if (!bus.flush) begin
      case (state_q)
        S_IDLE:  in_ready_c = 1'b1;
        S_DONE:  in_ready_c = bus.out_ready;
        default: in_ready_c = 1'b0;
      endcase
    end
    accept_c = bus.in_valid & in_ready_c;
  end

  // Signed overflow from the latched operand signs and the ALU result sign
  always_comb begin
    ovf_c = 1'b0;
    case (alu_op_q)
      OP_ADD: ovf_c = (alu_a_q[W-1] == alu_b_q[W-1]) && (bus.alu_res[W-1] != alu_a_q[W-1]);
      OP_SUB: ovf_c = (alu_a_q[W-1] != alu_b_q[W-1]) && (bus.alu_res[W-1] != alu_a_q[W-1]);
      default: ovf_c = 1'b0;
    endcase
  end

  // Next-state and register updates: flush wins, then the IDLE/EXEC/DONE flow, then op latch
  always_comb begin
    state_d     = state_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rd_pend_d   = rd_pend_q;
    wen_pend_d  = wen_pend_q;
    out_valid_d = out_valid_q;
    out_res_d   = out_res_q;
    out_zero_d  = out_zero_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    out_ovf_d   = out_ovf_q;
`ifdef OVF_TRAP_EN
    ovf_trap_d  = ovf_trap_q;
`endif

    if (bus.flush) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      out_wen_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_c) state_d = S_EXEC;
        end
        S_EXEC: begin
          out_valid_d = 1'b1;
          out_res_d   = bus.alu_res;
          out_zero_d  = bus.alu_zero;
          out_rd_d    = rd_pend_q;
          out_ovf_d   = ovf_c;
`ifdef OVF_TRAP_EN
          out_wen_d   = wen_pend_q & ~ovf_c;
          ovf_trap_d  = ovf_trap_q | ovf_c;
`else
          out_wen_d   = wen_pend_q;
`endif
          state_d     = S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            state_d     = accept_c ? S_EXEC : S_IDLE;
          end
        end
        default: begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
        end
      endcase
    end

    if (accept_c) begin
      alu_op_d   = dec_op_c;
      alu_a_d    = bus.in_a;
      alu_b_d    = bus.in_b;
      rd_pend_d  = bus.in_rd;
      wen_pend_d = dec_wen_c;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      alu_op_q    <= 3'b000;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rd_pend_q   <= '0;
      wen_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_res_q   <= '0;
      out_zero_q  <= 1'b0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
`ifdef OVF_TRAP_EN
      ovf_trap_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rd_pend_q   <= rd_pend_d;
      wen_pend_q  <= wen_pend_d;
      out_valid_q <= out_valid_d;
      out_res_q   <= out_res_d;
      out_zero_q  <= out_zero_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
      out_ovf_q   <= out_ovf_d;
      busy_q      <= busy_d;
`ifdef OVF_TRAP_EN
      ovf_trap_q  <= ovf_trap_d;
`endif
    end
  end

  assign bus.in_ready      = in_ready_c;
  assign bus.alu_operation = alu_op_q;
  assign bus.alu_a         = alu_a_q;
  assign bus.alu_b         = alu_b_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_res       = out_res_q;
  assign bus.out_zero      = out_zero_q;
  assign bus.out_rd        = out_rd_q;
  assign bus.out_wen       = out_wen_q;
  assign bus.out_ovf       = out_ovf_q;
  assign bus.busy          = busy_q;
`ifdef OVF_TRAP_EN
  assign bus.ovf_trap      = ovf_trap_q;
`endif

endmodule
